// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback-source encodings, funct3 access codes, LSU FSM states.
package pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} access_size_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
    } wb_regs_t;

    // Size lives in funct3[1:0]; unknown size codes fall back to a full word.
    function automatic access_size_t access_size(input logic [1:0] f3_lo);
        if (f3_lo == F3_B[1:0]) begin
            return SzByte;
        end else if (f3_lo == F3_H[1:0]) begin
            return SzHalf;
        end
        return SzWord;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/replication, alignment check and load extension.
module lsu_align
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic            aligned_o,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    access_size_t size;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;
    logic         sext;

    always_comb begin
        size      = access_size(funct3_i[1:0]);
        lane_byte = rdata_i[{offset_i, 3'b000} +: 8];
        lane_half = rdata_i[{offset_i[1], 4'b0000} +: 16];
        // funct3[2] set selects the unsigned load variants.
        sext      = ~funct3_i[2];
        aligned_o = 1'b1;
        wstrb_o   = 4'b1111;
        wdata_o   = wdata_i;
        rdata_o   = rdata_i;
        case (size)
            SzByte: begin
                wstrb_o = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{(XLEN-8){sext & lane_byte[7]}}, lane_byte};
            end
            SzHalf: begin
                aligned_o = ~offset_i[0];
                wstrb_o   = 4'b0011 << offset_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = {{(XLEN-16){sext & lane_half[15]}}, lane_half};
            end
            default: begin
                aligned_o = (offset_i == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: valid/ready data bus master, pipeline stall and MEM/WB register.
module mem_stage_lsu
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic            mem_write_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] wdata_m,
    input  logic [4:0]      rdm,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [2:0]      funct3_m,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    output logic            req_we,
    output logic [XLEN-1:0] req_wdata,
    output logic [3:0]      req_wstrb,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic            stall_m,
    output logic            misaligned_m,
    output logic            reg_write_w,
    output logic [1:0]      result_src_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] read_data_w,
    output logic [4:0]      rdw,
    output logic [XLEN-1:0] pc_plus4_w
);

    lsu_state_t      state_q, state_d;
    wb_regs_t        wb_q, wb_d;
    logic            is_load, is_store, access, aligned, complete;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] load_data;

    // A store flag wins if a malformed op also claims a memory result.
    assign is_store     = mem_write_m;
    assign is_load      = (result_src_m == RES_MEM) && !mem_write_m;
    assign access       = is_load || is_store;
    assign misaligned_m = access && !aligned;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3_i  (funct3_m),
        .offset_i  (alu_result_m[1:0]),
        .wdata_i   (wdata_m),
        .rdata_i   (rsp_rdata),
        .aligned_o (aligned),
        .wstrb_o   (wstrb),
        .wdata_o   (req_wdata),
        .rdata_o   (load_data)
    );

    assign req_addr  = {alu_result_m[XLEN-1:2], 2'b00};
    assign req_we    = is_store;
    assign req_wstrb = is_store ? wstrb : 4'b0000;

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    req_valid = 1'b1;
                    if (!req_ready) begin
                        state_d = REQ;
                    end else if (is_store) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    if (is_store) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_m = access && aligned && !complete;

    always_comb begin
        wb_d           = wb_q;
        wb_d.reg_write = 1'b0;
        if (!stall_m) begin
            wb_d.reg_write  = reg_write_m && !misaligned_m;
            wb_d.result_src = result_src_m;
            wb_d.alu_result = alu_result_m;
            wb_d.read_data  = (is_load && aligned) ? load_data : '0;
            wb_d.rd         = rdm;
            wb_d.pc_plus4   = pc_plus4_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
        end
    end

    assign reg_write_w  = wb_q.reg_write;
    assign result_src_w = wb_q.result_src;
    assign alu_result_w = wb_q.alu_result;
    assign read_data_w  = wb_q.read_data;
    assign rdw          = wb_q.rd;
    assign pc_plus4_w   = wb_q.pc_plus4;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against a byte-count based reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, wdata_m, pc_plus4_m;
    logic [4:0]  rdm;
    logic [2:0]  funct3_m;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall_m, misaligned_m, reg_write_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
    logic [4:0]  rdw;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .mem_write_m(mem_write_m),
        .alu_result_m(alu_result_m), .wdata_m(wdata_m), .rdm(rdm), .pc_plus4_m(pc_plus4_m),
        .funct3_m(funct3_m),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .stall_m(stall_m), .misaligned_m(misaligned_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .rdw(rdw), .pc_plus4_w(pc_plus4_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int o;
        logic [3:0] s;
        n = nbytes(f3);
        o = int'(addr % 4);
        s = '0;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        logic [31:0] r;
        n = nbytes(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int n;
        int o;
        longint m;
        longint v;
        n = nbytes(f3);
        o = int'(addr % 4);
        m = (longint'(1) << (8 * n)) - 1;
        v = (longint'(rd) >> (8 * o)) & m;
        if (n < 4 && f3[2] == 1'b0 && v >= (m + 1) / 2) v = v - (m + 1);
        return 32'(v);
    endfunction

    task automatic nop_inputs();
        reg_write_m = 1'b0; result_src_m = 2'b00; mem_write_m = 1'b0; alu_result_m = '0;
        wdata_m = '0; rdm = '0; pc_plus4_m = '0; funct3_m = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. Cycle c is counted from the first presented cycle.
    task automatic txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [4:0] rdv,
                       input int rdy_dly, input int rsp_dly, output int nstall);
        bit acc;
        bit ok;
        bit go;
        int done;
        logic [31:0] pc;
        acc = (kind != 0);
        ok  = (addr % nbytes(f3)) == 0;
        go  = acc && ok;
        pc  = $urandom;
        reg_write_m  = (kind != 2);
        result_src_m = (kind == 1) ? 2'b01 : 2'b00;
        mem_write_m  = (kind == 2);
        alu_result_m = addr; wdata_m = wd; rdm = rdv; pc_plus4_m = pc;
        funct3_m = f3; rsp_rdata = rd;
        done = !go ? 0 : ((kind == 2) ? rdy_dly : rdy_dly + rsp_dly);
        nstall = 0;
        for (int c = 0; c <= done; c++) begin
            req_ready = (c == rdy_dly);
            // Responses during the request phase or the handshake cycle must be ignored.
            rsp_valid = ((kind == 1) && (c == rdy_dly || c == done)) ||
                        (c < rdy_dly && $urandom_range(1) == 1);
            #1;
            chk1("misaligned", misaligned_m, acc && !ok);
            chk1("stall", stall_m, go && c != done);
            chk1("req_valid", req_valid, go && c <= rdy_dly);
            if (go && c <= rdy_dly) begin
                chk("req_addr", req_addr, addr & 32'hFFFF_FFFC);
                chk1("req_we", req_we, kind == 2);
                if (kind == 2) begin
                    chk("req_wstrb", 32'(req_wstrb), 32'(exp_strb(f3, addr)));
                    chk("req_wdata", req_wdata, exp_wdata(f3, wd));
                end
            end
            if (stall_m) nstall++;
            @(posedge clk);
            #1;
            if (c != done) chk1("bubble_rw", reg_write_w, 1'b0);
        end
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        chk1("wb_rw", reg_write_w, (kind != 2) && !(acc && !ok));
        chk("wb_alu", alu_result_w, addr);
        chk("wb_rd", 32'(rdw), 32'(rdv));
        chk("wb_pc4", pc_plus4_w, pc);
        chk("wb_src", 32'(result_src_w), (kind == 1) ? 32'd1 : 32'd0);
        if (kind == 1 && ok) chk("wb_rdata", read_data_w, exp_load(f3, addr, rd));
    endtask

    initial begin
        reset = 1'b0;
        nop_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk1("rst_rw", reg_write_w, 1'b0);
        chk("rst_alu", alu_result_w, 32'h0);
        chk("rst_rdata", read_data_w, 32'h0);
        chk("rst_pc4", pc_plus4_w, 32'h0);
        reset = 1'b1;
        #1;
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_stall", stall_m, 1'b0);
        chk1("rst_mis", misaligned_m, 1'b0);

        txn(0, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0, stalls);
        chk("alu_stalls", 32'(stalls), 32'd0);
        chk1("alu_rw", reg_write_w, 1'b1);

        txn(2, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 0, 0, stalls);
        chk("sw_stalls", 32'(stalls), 32'd0);

        txn(2, 3'b000, 32'h103, 32'h000000AB, 32'h0, 5'd0, 2, 0, stalls);
        chk("sb_stalls", 32'(stalls), 32'd2);

        txn(1, 3'b000, 32'h102, 32'h0, 32'h80FF1234, 5'd7, 0, 1, stalls);
        chk("lb_stalls", 32'(stalls), 32'd1);
        chk("lb_data", read_data_w, 32'hFFFFFFFF);

        txn(1, 3'b100, 32'h102, 32'h0, 32'h80FF1234, 5'd7, 0, 1, stalls);
        chk("lbu_data", read_data_w, 32'h000000FF);

        txn(1, 3'b001, 32'h101, 32'h0, 32'h12345678, 5'd3, 0, 1, stalls);
        chk("lh_mis_stalls", 32'(stalls), 32'd0);
        chk1("lh_mis_rw", reg_write_w, 1'b0);

        // Abandon a load sitting in WAIT via reset; the late response must be dropped.
        reg_write_m = 1'b1; result_src_m = 2'b01; mem_write_m = 1'b0; funct3_m = 3'b010;
        alu_result_m = 32'h200; rdm = 5'd9; pc_plus4_m = 32'h44; req_ready = 1'b1;
        #1;
        chk1("abort_stall0", stall_m, 1'b1);
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        #1;
        chk1("abort_wait_rv", req_valid, 1'b0);
        chk1("abort_wait_stall", stall_m, 1'b1);
        reset = 1'b0;
        nop_inputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hCAFEF00D;
        #1;
        chk1("abort_rw", reg_write_w, 1'b0);
        chk("abort_alu", alu_result_w, 32'h0);
        chk("abort_rdata", read_data_w, 32'h0);
        chk("abort_rd", 32'(rdw), 32'h0);
        chk("abort_pc4", pc_plus4_w, 32'h0);
        chk1("abort_rv", req_valid, 1'b0);
        chk1("abort_stall", stall_m, 1'b0);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        chk("abort_late_rdata", read_data_w, 32'h0);
        txn(1, 3'b010, 32'h300, 32'h0, 32'h11223344, 5'd2, 1, 2, stalls);
        chk("post_abort_stalls", 32'(stalls), 32'd3);

        for (int i = 0; i < 80; i++) begin
            int k;
            logic [2:0] f3;
            logic [31:0] a;
            k  = int'($urandom_range(2));
            f3 = (k == 2) ? 3'($urandom_range(2)) : 3'($urandom_range(7));
            a  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3));
            txn(k, f3, a, $urandom, $urandom, 5'($urandom), int'($urandom_range(3)),
                int'($urandom_range(3, 1)), stalls);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
